// File: rtl/i2c_byte_master_ctrl_pkg.sv
// Shared types and constants for the byte-level I2C master controller.
package i2c_byte_master_ctrl_pkg;

  localparam int unsigned QUARTERS_PER_BIT = 4;
  localparam int unsigned BITS_PER_BYTE    = 8;

  typedef enum logic [2:0] {
    CmdStart   = 3'd0,
    CmdStop    = 3'd1,
    CmdWrite   = 3'd2,
    CmdReadAck = 3'd3,
    CmdReadNak = 3'd4
  } i2c_cmd_t;

  typedef enum logic [1:0] {
    RspDone    = 2'd0,
    RspNak     = 2'd1,
    RspArbLost = 2'd2,
    RspErr     = 2'd3
  } i2c_rsp_t;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWbit,
    StWack,
    StRbit,
    StRack,
    StStop,
    StResp
  } i2c_mctrl_state_t;

  // Commands that are only meaningful while the controller owns the bus.
  function automatic logic cmd_is_bus_op(input logic [2:0] cmd);
    return cmd inside {CmdStop, CmdWrite, CmdReadAck, CmdReadNak};
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// SCL quarter-period divider: counts 0..CLK_DIV-1, held at zero by clear or
// by a stretch-hold request, and pulses tick_o on the last count.
module i2c_quarter_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic hold_i,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = !clr_i && !hold_i && (cnt_q == CntMax);
    if (clr_i || hold_i || (cnt_q == CntMax)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_byte_master_ctrl.sv
// Byte-level I2C master: START/repeated START, WRITE, READ_ACK/NAK, STOP.
// Define I2C_CLK_STRETCH_EN to let a slave holding SCL low stall the divider.
module i2c_byte_master_ctrl
  import i2c_byte_master_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned I2C_DATA_WIDTH = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [2:0]                cmd_i,
  input  logic [I2C_DATA_WIDTH-1:0] wdata_i,
  output logic                      rsp_valid_o,
  output logic [1:0]                rsp_o,
  output logic [I2C_DATA_WIDTH-1:0] rdata_o,
  output logic                      busy_o,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      scl_o,
  output logic                      sda_o
);

  localparam int unsigned W = I2C_DATA_WIDTH;
  localparam logic [2:0] LastBit = 3'(BITS_PER_BYTE - 1);
  localparam logic [1:0] LastQ   = 2'(QUARTERS_PER_BIT - 1);

  i2c_mctrl_state_t state_q, state_d;
  logic [1:0]       quarter_q, quarter_d;
  logic [2:0]       bit_q, bit_d;
  logic [W-1:0]     shift_q, shift_d;
  logic             nak_q, nak_d;
  logic             scl_q, scl_d;
  logic             sda_q, sda_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  i2c_rsp_t         rsp_q, rsp_d;
  logic [W-1:0]     rdata_q, rdata_d;

  logic     tick;
  logic     tick_clr;
  logic     stretch_hold;
  logic     fin;
  i2c_rsp_t fin_rsp;

`ifdef I2C_CLK_STRETCH_EN
  assign stretch_hold = scl_q && !scl_i;
`else
  logic unused_scl;
  assign unused_scl   = scl_i;
  assign stretch_hold = 1'b0;
`endif

  assign tick_clr = (state_q == StIdle) || (state_q == StResp);

  i2c_quarter_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_quarter_tick (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (tick_clr),
    .hold_i(stretch_hold),
    .tick_o(tick)
  );

  always_comb begin
    state_d     = state_q;
    quarter_d   = quarter_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    nak_d       = nak_q;
    scl_d       = scl_q;
    sda_d       = sda_q;
    busy_d      = busy_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rsp_d       = rsp_q;
    rdata_d     = rdata_q;
    fin         = 1'b0;
    fin_rsp     = RspDone;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i && ready_q) begin
          ready_d   = 1'b0;
          quarter_d = '0;
          bit_d     = '0;
          if (cmd_i == CmdStart) begin
            state_d = StStart;
            sda_d   = 1'b1;
          end else if (!(busy_q && cmd_is_bus_op(cmd_i))) begin
            state_d = StResp;
          end else begin
            case (cmd_i)
              CmdWrite: begin
                state_d = StWbit;
                shift_d = wdata_i;
                scl_d   = 1'b0;
                sda_d   = wdata_i[W-1];
              end
              CmdStop: begin
                state_d = StStop;
                sda_d   = 1'b0;
              end
              default: begin
                state_d = StRbit;
                scl_d   = 1'b0;
                sda_d   = 1'b1;
                nak_d   = (cmd_i == CmdReadNak);
              end
            endcase
          end
        end
      end

      StResp: begin
        fin     = 1'b1;
        fin_rsp = RspErr;
      end

      StStart: begin
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
          case (quarter_q)
            2'd0:    scl_d = 1'b1;
            2'd1:    sda_d = 1'b0;
            2'd2:    scl_d = 1'b0;
            default: begin
              busy_d = 1'b1;
              fin    = 1'b1;
            end
          endcase
        end
      end

      StWbit: begin
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
          case (quarter_q)
            2'd0: scl_d = 1'b1;
            2'd2: begin
              // Released SDA seen low: another master owns the bus.
              if (sda_q && !sda_i) begin
                scl_d   = 1'b1;
                sda_d   = 1'b1;
                busy_d  = 1'b0;
                fin     = 1'b1;
                fin_rsp = RspArbLost;
              end else begin
                scl_d = 1'b0;
              end
            end
            LastQ: begin
              if (bit_q == LastBit) begin
                state_d = StWack;
                sda_d   = 1'b1;
              end else begin
                bit_d   = bit_q + 3'd1;
                shift_d = {shift_q[W-2:0], 1'b0};
                sda_d   = shift_q[W-2];
              end
            end
            default: ;
          endcase
        end
      end

      StWack: begin
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
          case (quarter_q)
            2'd0: scl_d = 1'b1;
            2'd2: begin
              nak_d = sda_i;
              scl_d = 1'b0;
            end
            LastQ: begin
              fin     = 1'b1;
              fin_rsp = nak_q ? RspNak : RspDone;
            end
            default: ;
          endcase
        end
      end

      StRbit: begin
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
          case (quarter_q)
            2'd0: scl_d = 1'b1;
            2'd2: begin
              shift_d = {shift_q[W-2:0], sda_i};
              scl_d   = 1'b0;
            end
            LastQ: begin
              if (bit_q == LastBit) begin
                state_d = StRack;
                sda_d   = nak_q;
              end else begin
                bit_d = bit_q + 3'd1;
              end
            end
            default: ;
          endcase
        end
      end

      StRack: begin
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
          case (quarter_q)
            2'd0: scl_d = 1'b1;
            2'd2: scl_d = 1'b0;
            LastQ: begin
              sda_d   = 1'b1;
              rdata_d = shift_q;
              fin     = 1'b1;
            end
            default: ;
          endcase
        end
      end

      StStop: begin
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
          case (quarter_q)
            2'd0:  scl_d = 1'b1;
            2'd1:  sda_d = 1'b1;
            LastQ: begin
              busy_d = 1'b0;
              fin    = 1'b1;
            end
            default: ;
          endcase
        end
      end
    endcase

    if (fin) begin
      state_d     = StIdle;
      ready_d     = 1'b1;
      rsp_valid_d = 1'b1;
      rsp_d       = fin_rsp;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      quarter_q   <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      nak_q       <= 1'b0;
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_q       <= RspDone;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      quarter_q   <= quarter_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      nak_q       <= nak_d;
      scl_q       <= scl_d;
      sda_q       <= sda_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      rdata_q     <= rdata_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_o       = rsp_q;
  assign rdata_o     = rdata_q;
  assign busy_o      = busy_q;
  assign scl_o       = scl_q;
  assign sda_o       = sda_q;

endmodule

// File: doc/i2c_byte_master_ctrl.md
Name: i2c_byte_master_ctrl

Overview:
- Synthesizable byte-level I2C master controller that sequences START / repeated START, address/data WRITE, READ with ACK/NAK, and STOP on SCL/SDA.
- Sits between the DUT-side command source (register block / test sequencer) and the open-drain I2C pads.
- Is the bus master that the team's I2C slave BFM responds to.
- One command at a time; reports a per-command response.

Parameters:
- CLK_DIV, 4, system clocks per SCL quarter-period (min 2); SCL period = 4*CLK_DIV clocks.
- I2C_DATA_WIDTH, 8, byte width; fixed at 8, present for package consistency.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset; asynchronous, active-high
- cmd_valid_i  input  1  command request
- cmd_ready_o  output  1  controller can accept a command
- cmd_i  input  3  i2c_cmd_t: START, STOP, WRITE, READ_ACK, READ_NAK
- wdata_i  input  8  byte for WRITE; sampled at acceptance
- rsp_valid_o  output  1  single-cycle response strobe
- rsp_o  output  2  i2c_rsp_t: DONE, NAK, ARB_LOST, ERR
- rdata_o  output  8  byte received by READ_*; valid with rsp_valid_o
- busy_o  output  1  bus owned (between START and STOP/ARB_LOST)
- scl_i  input  1  sampled SCL pad
- sda_i  input  1  sampled SDA pad
- scl_o  output  1  1 = release (pad z), 0 = drive low
- sda_o  output  1  1 = release, 0 = drive low

Behaviour:
- Reset (async, immediate, including mid-command):
  - scl_o=1, sda_o=1, cmd_ready_o=1, rsp_valid_o=0, rsp_o=DONE, rdata_o=0, busy_o=0, FSM=IDLE, divider=0.
- Handshake:
  - Command accepted on the clock edge where cmd_valid_i && cmd_ready_o.
  - cmd_ready_o is high only in IDLE.
  - rsp_valid_o pulses exactly once per accepted command, with no backpressure.
  - cmd_ready_o returns high in the same cycle as rsp_valid_o.
- Quarter tick:
  - Divider counts 0..CLK_DIV-1; one tick per CLK_DIV clocks, with the first tick CLK_DIV clocks after acceptance.
  - Every command is a whole number of quarters.
  - rsp_valid_o asserts on the edge of its final tick.
- FSM states: IDLE, START, WBIT, WACK, RBIT, RACK, STOP, RESP.
- START: 4 quarters:
  - q0 sda=1; q1 scl=1; q2 sda=0; q3 scl=0.
  - If busy_o is set, this is a repeated START, with identical waveform.
  - Sets busy_o. Response DONE.
- WRITE: 8 bits MSB-first, 4 quarters each:
  - q0 scl=0 and sda=bit; q1 scl=1; q2 sample; q3 scl=0.
  - Then WACK: sda released, SDA sampled in q2.
  - 36 quarters total. Response DONE if ACK (0), NAK if 1.
- READ_ACK / READ_NAK:
  - 8 RBIT quarters-groups with sda released; SDA sampled in q2 of each bit, MSB-first into rdata_o.
  - Then RACK drives sda=0 (READ_ACK) or releases it (READ_NAK).
  - 36 quarters. Response DONE.
- STOP: 4 quarters:
  - q0 sda=0; q1 scl=1; q2 sda=1; q3 hold.
  - Clears busy_o. Response DONE.
- Illegal commands:
  - WRITE/READ_*/STOP with busy_o=0 → no bus activity; RESP on the next cycle with ERR.
  - An undefined cmd_i encoding is treated the same way.
- Arbitration loss:
  - Condition: in WBIT q2 with sda_o=1, sda_i=0 sampled.
  - Immediately release both lines, clear busy_o, abandon remaining bits, respond ARB_LOST.
- rdata_o holds its value until the next READ completes.

Optional Feature:
- I2C_CLK_STRETCH_EN
- Defined:
  - During any quarter where scl_o=1 but scl_i=0 (slave stretching), the divider holds.
  - The quarter ends CLK_DIV clocks after scl_i is seen high.
- Undefined: scl_i is ignored; timing is purely divider-based.

Decomposition:
- data_pkg gains i2c_cmd_t, i2c_rsp_t and i2c_mctrl_state_t (FSM enum).
- data_pkg also gains the localparams QUARTERS_PER_BIT=4 and BITS_PER_BYTE=8.
- One sub-module, i2c_quarter_tick: divider with clear, tick output, and the stretch-hold input (tied off when the macro is undefined).

Test Plan:
- CLK_DIV=4, START accepted at cycle 0 → scl/sda waveform per quarters; rsp_valid_o=DONE at cycle 16; busy_o=1.
- START, WRITE 0xA4, BFM ACKs → SDA bits 1,0,1,0,0,1,0,0 captured on SCL rise; rsp DONE 144 cycles after acceptance. Repeat with the BFM not ACKing → NAK.
- START, WRITE addr|R, READ_ACK with BFM data 0x5C, then READ_NAK with data 0x03 → rdata_o=0x5C then 0x03. Master drives SDA=0 on the 9th bit of the first read and releases it on the second. STOP → busy_o=0.
- WRITE while busy_o=0 → rsp ERR one cycle after acceptance; scl_o/sda_o stay 1.
- During WRITE 0xFF, force sda_i=0 at bit 3 q2 → ARB_LOST; both lines released within 1 cycle; busy_o=0.
- With I2C_CLK_STRETCH_EN, hold scl_i low 20 cycles during a WRITE bit → response delayed by exactly 20 cycles. rst_i asserted mid-READ → all outputs at reset values asynchronously.
